// File: rtl/tcdm_resp_pkg.sv
// Shared types and constants for the TCDM memory responder.
package tcdm_resp_pkg;

    // Width of the port index carried through the response pipeline; covers up to 16 ports.
    localparam int PORT_IDX_W = 4;

    localparam logic [31:0] TCDM_ERR_DATA = 32'hDEAD_BEEF;
    localparam int          WORD_BYTES    = 4;

    typedef struct packed {
        logic                  valid;
        logic [PORT_IDX_W-1:0] port;
        logic [31:0]           data;
    } resp_pipe_t;

    // Merge the bytes of new_w selected by be into old_w.
    function automatic logic [31:0] apply_be(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  be);
        logic [31:0] res;
        res = old_w;
        for (int b = 0; b < WORD_BYTES; b++) begin
            if (be[b]) res[8*b +: 8] = new_w[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/tcdm_resp_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts at the pointer, pointer moves past the winner.
module tcdm_resp_rr_arbiter
    import tcdm_resp_pkg::*;
#(
    parameter int NB_PORTS = 2,
    parameter int IDX_W    = (NB_PORTS > 1) ? $clog2(NB_PORTS) : 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clear_i,
    input  logic                en_i,
    input  logic [NB_PORTS-1:0] req_i,
    output logic [NB_PORTS-1:0] gnt_o,
    output logic [IDX_W-1:0]    idx_o,
    output logic                valid_o
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;

    // Pick the first requester at or after the pointer, wrapping around.
    always_comb begin
        int k;
        k       = 0;
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        if (en_i) begin
            for (int i = 0; i < NB_PORTS; i++) begin
                k = (int'(ptr_q) + i) % NB_PORTS;
                if (!valid_o && req_i[k]) begin
                    valid_o  = 1'b1;
                    gnt_o[k] = 1'b1;
                    idx_o    = IDX_W'(k);
                end
            end
        end
    end

    // Next pointer: one past the winner, unchanged without a grant.
    always_comb begin
        ptr_d = ptr_q;
        if (valid_o) begin
            ptr_d = (int'(idx_o) == NB_PORTS - 1) ? '0 : idx_o + IDX_W'(1);
        end
    end

    // Pointer register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)      ptr_q <= '0;
        else if (clear_i) ptr_q <= '0;
        else              ptr_q <= ptr_d;
    end

endmodule

// File: rtl/tcdm_mem_responder.sv
// TCDM slave-side memory model: NB_PORTS round-robin arbitrated ports onto one word array,
// reads answered after a fixed LATENCY. Optional grant throttle under TCDM_RESP_STALL_EN.
module tcdm_mem_responder
    import tcdm_resp_pkg::*;
#(
    parameter int          NB_PORTS  = 2,
    parameter int          MEM_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          LATENCY   = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clear_i,
    input  logic [NB_PORTS-1:0]      tcdm_req_i,
    output logic [NB_PORTS-1:0]      tcdm_gnt_o,
    input  logic [NB_PORTS-1:0][31:0] tcdm_add_i,
    input  logic [NB_PORTS-1:0]      tcdm_wen_i,
    input  logic [NB_PORTS-1:0][3:0] tcdm_be_i,
    input  logic [NB_PORTS-1:0][31:0] tcdm_data_i,
    output logic [NB_PORTS-1:0][31:0] tcdm_r_data_o,
    output logic [NB_PORTS-1:0]      tcdm_r_valid_o,
`ifdef TCDM_RESP_STALL_EN
    input  logic [3:0]               stall_cfg_i,
`endif
    output logic                     busy_o,
    output logic                     err_o,
    output logic [31:0]              rd_cnt_o,
    output logic [31:0]              wr_cnt_o
);

    localparam int          IDX_W = (NB_PORTS > 1) ? $clog2(NB_PORTS) : 1;
    localparam int          AW    = $clog2(MEM_WORDS);
    localparam logic [32:0] SPAN  = 33'(MEM_WORDS) << 2;

    logic             grant_en;
    logic             stall_ok;
    logic             gnt_valid;
    logic [IDX_W-1:0] gnt_idx;

    logic [31:0]      sel_add;
    logic [31:0]      sel_data;
    logic [3:0]       sel_be;
    logic             sel_wen;
    logic [31:0]      off;
    logic             in_range;
    logic [AW-1:0]    word_idx;
    logic [31:0]      rd_data;

    logic [31:0]      mem_q [MEM_WORDS];
    resp_pipe_t       pipe_q [LATENCY];
    resp_pipe_t       pipe_d;
    resp_pipe_t       resp_out;
    logic [NB_PORTS-1:0][31:0] r_hold_q;

    logic [31:0]      rd_cnt_q;
    logic [31:0]      wr_cnt_q;
    logic             err_q;

    // No grants while in reset or during a soft clear.
    assign grant_en = rst_ni && !clear_i && stall_ok;

    tcdm_resp_rr_arbiter #(
        .NB_PORTS (NB_PORTS),
        .IDX_W    (IDX_W)
    ) i_arb (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .en_i    (grant_en),
        .req_i   (tcdm_req_i),
        .gnt_o   (tcdm_gnt_o),
        .idx_o   (gnt_idx),
        .valid_o (gnt_valid)
    );

`ifdef TCDM_RESP_STALL_EN
    logic [3:0] stall_q;

    // Throttle: reload after every grant, count down to zero before the next grant.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)             stall_q <= '0;
        else if (clear_i)        stall_q <= '0;
        else if (gnt_valid)      stall_q <= stall_cfg_i;
        else if (stall_q != '0)  stall_q <= stall_q - 4'd1;
    end

    assign stall_ok = (stall_q == 4'd0);
`else
    assign stall_ok = 1'b1;
`endif

    // Select the granted request and decode its address.
    always_comb begin
        sel_add  = tcdm_add_i[gnt_idx];
        sel_data = tcdm_data_i[gnt_idx];
        sel_be   = tcdm_be_i[gnt_idx];
        sel_wen  = tcdm_wen_i[gnt_idx];
        off      = sel_add - BASE_ADDR;
        in_range = (sel_add >= BASE_ADDR) && ({1'b0, off} < SPAN);
        word_idx = off[AW+1:2];
        rd_data  = in_range ? mem_q[word_idx] : TCDM_ERR_DATA;
    end

    // Word array; contents deliberately survive reset and clear.
    always_ff @(posedge clk_i) begin
        if (gnt_valid && !sel_wen && in_range) begin
            mem_q[word_idx] <= apply_be(mem_q[word_idx], sel_data, sel_be);
        end
    end

    // Entry loaded into the response pipeline on a read grant.
    always_comb begin
        pipe_d       = '0;
        pipe_d.valid = gnt_valid && sel_wen;
        pipe_d.port  = PORT_IDX_W'(gnt_idx);
        pipe_d.data  = rd_data;
    end

    // Fixed-latency response shift register; in-flight reads are dropped on reset/clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
        end else if (clear_i) begin
            for (int i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= pipe_d;
            for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign resp_out = pipe_q[LATENCY-1];

    // Per-port hold of the last delivered read data.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_hold_q <= '0;
        end else if (clear_i) begin
            r_hold_q <= '0;
        end else if (resp_out.valid) begin
            r_hold_q[resp_out.port[IDX_W-1:0]] <= resp_out.data;
        end
    end

    // Route the pipeline head to its port; other ports show their held data.
    always_comb begin
        busy_o = 1'b0;
        for (int i = 0; i < LATENCY; i++) busy_o = busy_o | pipe_q[i].valid;
        for (int p = 0; p < NB_PORTS; p++) begin
            tcdm_r_valid_o[p] = resp_out.valid && (resp_out.port == PORT_IDX_W'(p));
            tcdm_r_data_o[p]  = tcdm_r_valid_o[p] ? resp_out.data : r_hold_q[p];
        end
    end

    // Access counters and sticky range error; range errors still count as accesses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
            err_q    <= 1'b0;
        end else if (clear_i) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
            err_q    <= 1'b0;
        end else if (gnt_valid) begin
            if (sel_wen) rd_cnt_q <= rd_cnt_q + 32'd1;
            else         wr_cnt_q <= wr_cnt_q + 32'd1;
            if (!in_range) err_q <= 1'b1;
        end
    end

    assign rd_cnt_o = rd_cnt_q;
    assign wr_cnt_o = wr_cnt_q;
    assign err_o    = err_q;

endmodule
